iir_post_decim: RTL and testbench

IIR_POST_DECIM -- requirements
Module: iir_post_decim

---
 rtl/iir_post_decim_pkg.sv | 18 +
 rtl/sample_fifo.sv | 64 ++++++
 rtl/iir_post_decim.sv | 102 ++++++++++
 tb/tb_iir_post_decim.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/iir_post_decim_pkg.sv
// Shared IIR constants: sample/decimation parameter limits and accumulator sizing.
// Used by the IIR filter and its post-decimation stage.
package iir_post_decim_pkg;

  localparam int unsigned IIR_N_DEFAULT        = 14;
  localparam int unsigned IIR_N_MIN            = 1;
  localparam int unsigned IIR_DEC_LOG2_DEFAULT = 2;
  localparam int unsigned IIR_DEC_LOG2_MIN     = 1;
  localparam int unsigned IIR_DEC_LOG2_MAX     = 4;
  localparam int unsigned IIR_DEPTH_MIN        = 2;

  // Accumulator width: an (n+1)-bit sample plus dec_log2 bits of block growth.
  function automatic int unsigned iir_acc_width(input int unsigned n,
                                                input int unsigned dec_log2);
    return n + 1 + dec_log2;
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// sample_fifo: synchronous FIFO of decimated samples.
// Ports:
//   clk, rst       - clock, async active-low reset (clears pointers, storage, level)
//   push, wdata    - write request and data; ignored when full unless a pop occurs
//   pop            - read request; ignored when empty
//   rdata          - head entry
//   full, empty    - registered occupancy flags
//   level          - current occupancy, 0..DEPTH
module sample_fifo #(
  parameter int unsigned width = 15,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [width-1:0]         wdata,
  input  logic                     pop,
  output logic [width-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;

  logic [width-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push_c;
  logic             do_pop_c;
  logic [LW-1:0]    level_nxt_c;

  // A pop frees the head slot on the same edge, so a full FIFO still takes a push.
  always_comb begin
    do_pop_c    = pop && !empty;
    do_push_c   = push && (!full || do_pop_c);
    level_nxt_c = level + LW'(do_push_c) - LW'(do_pop_c);
  end

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
    end else begin
      if (do_push_c) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (do_pop_c) rd_ptr <= rd_ptr + PW'(1);
      level <= level_nxt_c;
      empty <= (level_nxt_c == '0);
      full  <= (level_nxt_c == LW'(DEPTH));
    end
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/iir_post_decim.sv
// iir_post_decim: block-average decimator (factor 2^DEC_LOG2) behind an IIR stage,
// with round-half-up, saturation and an output FIFO with sticky drop flag.
// Ports:
//   clk, rst        - clock, async active-low reset
//   y_in, in_en     - input sample and its valid qualifier
//   out_data        - FIFO head (decimated sample)
//   out_valid       - FIFO non-empty
//   out_ready       - consumer pops the head on this edge
//   fifo_level      - FIFO occupancy
//   ovf, ovf_clr    - sticky drop flag and its synchronous clear
module iir_post_decim
  import iir_post_decim_pkg::*;
#(
  parameter int unsigned N        = IIR_N_DEFAULT,
  parameter int unsigned DEC_LOG2 = IIR_DEC_LOG2_DEFAULT,
  parameter int unsigned DEPTH    = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [N:0]       y_in,
  input  logic                    in_en,
  output logic signed [N:0]       out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [$clog2(DEPTH):0]  fifo_level,
  output logic                    ovf,
  input  logic                    ovf_clr
);

  localparam int unsigned AW = iir_acc_width(N, DEC_LOG2);
  localparam int unsigned D  = 1 << DEC_LOG2;
  localparam logic [AW:0] RND = (AW+1)'(D / 2);

  if (N < IIR_N_MIN || DEC_LOG2 < IIR_DEC_LOG2_MIN || DEC_LOG2 > IIR_DEC_LOG2_MAX ||
      DEPTH < IIR_DEPTH_MIN || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_params
    $error("iir_post_decim: illegal N, DEC_LOG2 or DEPTH");
  end

  logic [AW-1:0]       acc;
  logic [DEC_LOG2-1:0] cnt;
  logic [AW-1:0]       y_ext_c;
  logic [AW:0]         sum_c;
  logic [N+1:0]        q_c;
  logic [N:0]          res_c;
  logic                last_c;
  logic                fifo_full;
  logic                fifo_empty;
  logic                drop_c;
  logic [N:0]          fifo_rdata;

  // Block sum including the current sample and the rounding offset; one guard bit.
  always_comb begin
    y_ext_c = {{DEC_LOG2{y_in[N]}}, y_in};
    sum_c   = {acc[AW-1], acc} + {y_ext_c[AW-1], y_ext_c} + RND;
    last_c  = in_en && (cnt == DEC_LOG2'(D - 1));
    // Arithmetic shift right by DEC_LOG2 is a bit slice of the sign-extended sum.
    q_c     = sum_c[AW:DEC_LOG2];
    if (q_c[N+1] != q_c[N]) res_c = {q_c[N+1], {N{~q_c[N+1]}}};
    else                    res_c = q_c[N:0];
    drop_c  = last_c && fifo_full && !(out_ready && !fifo_empty);
  end

  // Accumulator and sample counter; both restart on the block's last sample.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc <= '0;
      cnt <= '0;
    end else if (last_c) begin
      acc <= '0;
      cnt <= '0;
    end else if (in_en) begin
      acc <= acc + y_ext_c;
      cnt <= cnt + DEC_LOG2'(1);
    end
  end

  // Sticky drop flag; a drop on the clearing edge wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         ovf <= 1'b0;
    else if (drop_c)  ovf <= 1'b1;
    else if (ovf_clr) ovf <= 1'b0;
  end

  sample_fifo #(
    .width (N + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (last_c),
    .wdata (res_c),
    .pop   (out_ready),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign out_data  = fifo_rdata;
  assign out_valid = !fifo_empty;

endmodule

// File: tb/tb_iir_post_decim.sv
module tb_iir_post_decim;

  localparam int N     = 14;
  localparam int DL    = 2;
  localparam int D     = 1 << DL;
  localparam int DEPTH = 4;
  localparam int SMAX  = (1 << N) - 1;
  localparam int SMIN  = -(1 << N);

  logic                clk = 1'b0;
  logic                rst;
  logic signed [N:0]   y_in;
  logic                in_en;
  logic signed [N:0]   out_data;
  logic                out_valid;
  logic                out_ready;
  logic [2:0]          fifo_level;
  logic                ovf;
  logic                ovf_clr;

  int vectors = 0;
  int errors  = 0;

  // Reference model state: running block sum, sample count, result queue, drop flag.
  int msum = 0;
  int mcnt = 0;
  int mq[$];
  bit movf = 1'b0;

  iir_post_decim #(.N(N), .DEC_LOG2(DL), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .y_in       (y_in),
    .in_en      (in_en),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .fifo_level (fifo_level),
    .ovf        (ovf),
    .ovf_clr    (ovf_clr)
  );

  always #5 clk = ~clk;

  // Mean of a block: floor((sum + D/2) / D), clamped to the sample range.
  function automatic int exp_mean(input int s);
    int t;
    int q;
    t = s + D / 2;
    if (t >= 0) q = t / D;
    else        q = -((-t + D - 1) / D);
    if (q > SMAX) q = SMAX;
    if (q < SMIN) q = SMIN;
    return q;
  endfunction

  task automatic model_reset();
    msum = 0;
    mcnt = 0;
    mq.delete();
    movf = 1'b0;
  endtask

  // Drive one cycle of inputs, advance the model, and step to 1 time unit after the edge.
  task automatic apply(input int y, input bit en, input bit rdy, input bit clr);
    bit pop;
    bit push;
    bit drop;
    int r;
    y_in      = (N+1)'(y);
    in_en     = en;
    out_ready = rdy;
    ovf_clr   = clr;
    pop  = rdy && (mq.size() > 0);
    push = 1'b0;
    drop = 1'b0;
    r    = 0;
    if (en) begin
      msum += y;
      mcnt++;
      if (mcnt == D) begin
        r    = exp_mean(msum);
        push = 1'b1;
        msum = 0;
        mcnt = 0;
      end
    end
    if (pop) void'(mq.pop_front());
    if (push) begin
      if (mq.size() < DEPTH) mq.push_back(r);
      else                   drop = 1'b1;
    end
    if (drop)     movf = 1'b1;
    else if (clr) movf = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_init();
    rst = 1'b0; y_in = '0; in_en = 1'b0; out_ready = 1'b0; ovf_clr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL init_valid: got %0b want 0", out_valid); end
    vectors++; if (int'(fifo_level) !== 0) begin errors++; $display("FAIL init_level: got %0d want 0", fifo_level); end
    vectors++; if (ovf !== 1'b0) begin errors++; $display("FAIL init_ovf: got %0b want 0", ovf); end
    vectors++; if (int'(out_data) !== 0) begin errors++; $display("FAIL init_data: got %0d want 0", out_data); end
    rst = 1'b1;
    apply(0, 0, 0, 0);
  endtask

  task automatic test_average();
    int ys[4] = '{100, 200, 300, 400};
    for (int i = 0; i < 3; i++) begin
      apply(ys[i], 1, 1, 0);
      vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL avg_early_valid[%0d]: got %0b want 0", i, out_valid); end
    end
    apply(ys[3], 1, 1, 0);
    vectors++; if (out_valid !== 1'b1) begin errors++; $display("FAIL avg_valid: got %0b want 1", out_valid); end
    vectors++; if (int'(out_data) !== 250) begin errors++; $display("FAIL avg_data: got %0d want 250", out_data); end
    vectors++; if (int'(fifo_level) !== 1) begin errors++; $display("FAIL avg_level: got %0d want 1", fifo_level); end
    apply(0, 0, 1, 0);
    vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL avg_pop_valid: got %0b want 0", out_valid); end
  endtask

  task automatic test_rounding();
    int blk[3][4] = '{'{-1, -2, -2, -2}, '{SMAX, SMAX, SMAX, SMAX}, '{SMIN, SMIN, SMIN, SMIN}};
    int want[3]   = '{-2, SMAX, SMIN};
    for (int c = 0; c < 3; c++) begin
      for (int s = 0; s < 4; s++) apply(blk[c][s], 1, 1, 0);
      vectors++; if (out_valid !== 1'b1) begin errors++; $display("FAIL round_valid[%0d]: got %0b want 1", c, out_valid); end
      vectors++; if (int'(out_data) !== want[c]) begin errors++; $display("FAIL round_data[%0d]: got %0d want %0d", c, out_data, want[c]); end
      apply(0, 0, 1, 0);
    end
  endtask

  task automatic test_backpressure();
    int bp[5] = '{1000, -2000, 3000, -4000, 5000};
    for (int b = 0; b < 5; b++)
      for (int s = 0; s < 4; s++) apply(bp[b], 1, 0, 0);
    vectors++; if (int'(fifo_level) !== 4) begin errors++; $display("FAIL bp_level: got %0d want 4", fifo_level); end
    vectors++; if (ovf !== 1'b1) begin errors++; $display("FAIL bp_ovf: got %0b want 1", ovf); end
    for (int k = 0; k < 4; k++) begin
      vectors++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_drain_valid[%0d]: got %0b want 1", k, out_valid); end
      vectors++; if (int'(out_data) !== bp[k]) begin errors++; $display("FAIL bp_drain_data[%0d]: got %0d want %0d", k, out_data, bp[k]); end
      apply(0, 0, 1, 0);
    end
    vectors++; if (int'(fifo_level) !== 0) begin errors++; $display("FAIL bp_empty_level: got %0d want 0", fifo_level); end
    vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty_valid: got %0b want 0", out_valid); end
    vectors++; if (ovf !== 1'b1) begin errors++; $display("FAIL bp_ovf_sticky: got %0b want 1", ovf); end
    apply(0, 0, 0, 1);
    vectors++; if (ovf !== 1'b0) begin errors++; $display("FAIL bp_ovf_clr: got %0b want 0", ovf); end
  endtask

  task automatic test_full_pop();
    int fp[5] = '{11, 22, 33, 44, 55};
    for (int b = 0; b < 4; b++)
      for (int s = 0; s < 4; s++) apply(fp[b], 1, 0, 0);
    vectors++; if (int'(fifo_level) !== 4) begin errors++; $display("FAIL fp_fill_level: got %0d want 4", fifo_level); end
    for (int s = 0; s < 3; s++) apply(fp[4], 1, 0, 0);
    apply(fp[4], 1, 1, 0);
    vectors++; if (int'(fifo_level) !== 4) begin errors++; $display("FAIL fp_level: got %0d want 4", fifo_level); end
    vectors++; if (ovf !== 1'b0) begin errors++; $display("FAIL fp_ovf: got %0b want 0", ovf); end
    for (int k = 1; k < 5; k++) begin
      vectors++; if (int'(out_data) !== fp[k]) begin errors++; $display("FAIL fp_order[%0d]: got %0d want %0d", k, out_data, fp[k]); end
      apply(0, 0, 1, 0);
    end
    vectors++; if (int'(fifo_level) !== 0) begin errors++; $display("FAIL fp_drain_level: got %0d want 0", fifo_level); end
  endtask

  task automatic test_gating();
    int g[4] = '{10, 20, 30, 40};
    int junk;
    for (int i = 0; i < 8; i++) begin
      junk = int'($urandom_range(0, 32767)) - 16384;
      if (i % 2 == 0) apply(g[i / 2], 1, 1, 0);
      else            apply(junk, 0, 1, 0);
      if (i == 6) begin
        vectors++; if (out_valid !== 1'b1) begin errors++; $display("FAIL gate_valid: got %0b want 1", out_valid); end
        vectors++; if (int'(out_data) !== 25) begin errors++; $display("FAIL gate_data: got %0d want 25", out_data); end
      end
    end
    vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL gate_after_valid: got %0b want 0", out_valid); end
  endtask

  task automatic test_reset_partial();
    for (int b = 0; b < 5; b++)
      for (int s = 0; s < 4; s++) apply(7, 1, 0, 0);
    vectors++; if (ovf !== 1'b1) begin errors++; $display("FAIL rst_pre_ovf: got %0b want 1", ovf); end
    apply(4, 1, 0, 0);
    apply(4, 1, 0, 0);
    rst = 1'b0;
    #1;
    model_reset();
    vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %0b want 0", out_valid); end
    vectors++; if (int'(fifo_level) !== 0) begin errors++; $display("FAIL rst_level: got %0d want 0", fifo_level); end
    vectors++; if (ovf !== 1'b0) begin errors++; $display("FAIL rst_ovf: got %0b want 0", ovf); end
    vectors++; if (int'(out_data) !== 0) begin errors++; $display("FAIL rst_data: got %0d want 0", out_data); end
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int s = 0; s < 3; s++) begin
      apply(8, 1, 0, 0);
      vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_partial_valid[%0d]: got %0b want 0", s, out_valid); end
    end
    apply(8, 1, 0, 0);
    vectors++; if (int'(fifo_level) !== 1) begin errors++; $display("FAIL rst_block_level: got %0d want 1", fifo_level); end
    vectors++; if (int'(out_data) !== 8) begin errors++; $display("FAIL rst_block_data: got %0d want 8", out_data); end
    apply(0, 0, 1, 0);
    vectors++; if (int'(fifo_level) !== 0) begin errors++; $display("FAIL rst_pop_level: got %0d want 0", fifo_level); end
  endtask

  task automatic test_random();
    int y;
    int sel;
    bit en;
    bit rdy;
    bit clr;
    for (int i = 0; i < 400; i++) begin
      sel = int'($urandom_range(0, 9));
      if (sel == 0)      y = SMIN;
      else if (sel == 1) y = SMAX;
      else               y = int'($urandom_range(0, 32767)) - 16384;
      en  = ($urandom_range(0, 9) < 7);
      rdy = ($urandom_range(0, 9) < 4);
      clr = ($urandom_range(0, 9) == 0);
      apply(y, en, rdy, clr);
      vectors++; if (out_valid !== (mq.size() > 0)) begin errors++; $display("FAIL rand_valid[%0d]: got %0b want %0b", i, out_valid, mq.size() > 0); end
      vectors++; if (int'(fifo_level) !== mq.size()) begin errors++; $display("FAIL rand_level[%0d]: got %0d want %0d", i, fifo_level, mq.size()); end
      vectors++; if (ovf !== movf) begin errors++; $display("FAIL rand_ovf[%0d]: got %0b want %0b", i, ovf, movf); end
      if (mq.size() > 0) begin
        vectors++; if (int'(out_data) !== mq[0]) begin errors++; $display("FAIL rand_data[%0d]: got %0d want %0d", i, out_data, mq[0]); end
      end
    end
  endtask

  initial begin
    test_reset_init();
    test_average();
    test_rounding();
    test_backpressure();
    test_full_pop();
    test_gating();
    test_reset_partial();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
